// File: rtl/mod17_pkg.sv
// Constants shared by the mod-17 residue reducer and composer.
package mod17_pkg;

  localparam int unsigned MOD_P    = 17;
  localparam int unsigned MAX_REM  = 16;
  localparam int unsigned MAX_Q    = 252645135;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PIPE_LAT = 4;

endpackage : mod17_pkg

// File: rtl/mod17_err_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module mod17_err_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : mod17_err_counter

// File: rtl/mod17_compose.sv
// Rebuilds dividend = 17*quotient + remainder in a 4-stage free-running pipeline,
// flagging out-of-range remainders and 32-bit overflow.
module mod17_compose
  import mod17_pkg::*;
#(
  parameter int unsigned Q_W   = 28,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mark_in,
  input  logic [Q_W-1:0]    quotient,
  input  logic [4:0]        reminder,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] divident,
  output logic              mark_out,
  output logic              err_range,
  output logic              err_ovf,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned SUM_W = DATA_W + 1;

  // S1
  logic [Q_W-1:0]    q1_q;
  logic [4:0]        r1_q;
  logic              m1_q;
  // S2
  logic [SUM_W-1:0]  p2_q;
  logic [4:0]        r2_q;
  logic              rng2_q;
  logic              m2_q;
  // S3
  logic [SUM_W-1:0]  s3_q;
  logic              rng3_q;
  logic              m3_q;
  // S4 (outputs)
  logic [DATA_W-1:0] div_q;
  logic              mark_q;
  logic              rng_q;
  logic              ovf_q;

  logic [SUM_W-1:0]  p_d;
  logic              rng_d;
  logic [SUM_W-1:0]  s_d;
  logic              err_any_c;
  logic [DATA_W-1:0] div_d;

  // 17*q computed as (q<<4)+q, carried at 33 bits so overflow is visible.
  always_comb begin
    p_d       = SUM_W'({q1_q, 4'b0000}) + SUM_W'(q1_q);
    rng_d     = (r1_q > 5'(MAX_REM));
    s_d       = p2_q + SUM_W'(r2_q);
    err_any_c = rng3_q | s3_q[DATA_W];
    div_d     = err_any_c ? '0 : s3_q[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q   <= '0;
      r1_q   <= '0;
      m1_q   <= 1'b0;
      p2_q   <= '0;
      r2_q   <= '0;
      rng2_q <= 1'b0;
      m2_q   <= 1'b0;
      s3_q   <= '0;
      rng3_q <= 1'b0;
      m3_q   <= 1'b0;
      div_q  <= '0;
      mark_q <= 1'b0;
      rng_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q1_q   <= quotient;
      r1_q   <= reminder;
      m1_q   <= mark_in;
      p2_q   <= p_d;
      r2_q   <= r1_q;
      rng2_q <= rng_d;
      m2_q   <= m1_q;
      s3_q   <= s_d;
      rng3_q <= rng2_q;
      m3_q   <= m2_q;
      div_q  <= div_d;
      mark_q <= m3_q;
      rng_q  <= rng3_q;
      ovf_q  <= s3_q[DATA_W];
    end
  end

  // Counts on the same edge that loads the S4 outputs.
  mod17_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (m3_q & err_any_c),
    .cnt_o (err_cnt)
  );

  assign divident  = div_q;
  assign mark_out  = mark_q;
  assign err_range = rng_q;
  assign err_ovf   = ovf_q;

endmodule : mod17_compose

// File: doc/mod17_compose.md
Name: mod17_compose

Overview:
- Inverse of the mod-17 residue reducer: rebuilds a 32-bit dividend from a quotient and a remainder, dividend = 17*quotient + remainder.
- Sits on the return path of the residue datapath and feeds reconstructed words back to the 32-bit domain.
- Fully pipelined, one input per clock, fixed latency.
- A `mark_in`/`mark_out` strobe travels alongside the data; range and overflow violations are flagged and counted.

Parameters:
- Q_W, 28, quotient width; fixed so that 17*(2^Q_W-1) fits in 33 bits.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mark_in  in  1  input word valid strobe
- quotient  in  Q_W  quotient operand
- reminder  in  5  remainder operand; legal range 0..16
- cnt_clr  in  1  synchronous clear of err_cnt
- divident  out  32  reconstructed dividend
- mark_out  out  1  output valid strobe; mark_in delayed 4 cycles
- err_range  out  1  remainder > 16 for this word
- err_ovf  out  1  17*quotient + reminder > 2^32-1 for this word
- err_cnt  out  CNT_W  count of marked words with any error; saturating

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all pipeline registers and all outputs are 0 (divident=0, mark_out=0, err_range=0, err_ovf=0, err_cnt=0).
- Reset asserted mid-stream discards every in-flight word. The first mark_out after release is exactly 4 cycles after the first post-reset mark_in.
- The pipeline is free-running: data registers update every cycle regardless of mark_in. Outputs are meaningful only when mark_out=1.
- Stage S1: register quotient, reminder and mark_in.
- Stage S2:
  - p = {S1.quotient,4'b0} + S1.quotient, 33-bit unsigned.
  - rng = (S1.reminder > 16).
  - Forward S1.reminder and mark.
- Stage S3: s = p + zero-extended S2.reminder, 33-bit unsigned. Forward rng and mark.
- Stage S4 (output registers):
  - err_range = rng.
  - err_ovf = s[32].
  - divident = (rng | s[32]) ? 0 : s[31:0].
  - mark_out = S3.mark.
- Latency: exactly 4 clk edges from mark_in/quotient/reminder sampled to divident/mark_out valid. Throughput is 1 word per cycle; back-to-back marks are legal with no bubbles.
- Arithmetic: all unsigned, no truncation before the 33-bit sum.
  - Boundary: quotient=252645135 (0x0F0F0F0F) with remainder=0 gives exactly 0xFFFFFFFF and is legal.
  - Any larger quotient, or that quotient with remainder≥1, sets err_ovf.
- Both errors may be set together; divident is then 0.
- err_cnt update, evaluated in priority order on each edge:
  1. cnt_clr=1: err_cnt←0. Clear wins over a simultaneous increment, and that error is not counted.
  2. Else mark_out-stage word has mark=1 and (rng|s[32]): err_cnt←err_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  3. Else: hold.
- The counter updates in the same edge that loads the S4 outputs, so err_cnt reflects a word's error when that word's mark_out is high.
- Error flags on unmarked cycles are don't-care and never counted.

Decomposition:
- Shared package mod17_pkg holds:
  - MOD_P=17
  - MAX_REM=16
  - MAX_Q=252645135
  - DATA_W=32
  - PIPE_LAT=4
- The reducer block and this block both use these constants.
- One natural sub-module, mod17_err_counter: saturating counter with sync clear and async reset, parameterised by CNT_W.
- The arithmetic stays inline in mod17_compose.

Test Plan:
1. Reset then mark_in pulse, q=0, r=0 → 4 cycles later mark_out=1, divident=0, no errors, err_cnt=0.
2. Back-to-back marks (q=5,r=3), (q=1000,r=16), (q=0x0F0F0F0F,r=0) → consecutive mark_out cycles with divident 88, 17016, 0xFFFFFFFF; no errors.
3. (q=0x0F0F0F0F,r=1) then (q=0x0FFFFFFF,r=16) → err_ovf=1 and divident=0 on both; err_cnt=2.
4. (q=10,r=17) and (q=0x0FFFFFFF,r=31) → err_range=1 on both; second word also err_ovf=1; divident=0; err_cnt increments once per word.
5. Erroneous word with cnt_clr asserted in its output cycle → err_cnt=0. Preload near 2^CNT_W-1 via repeated errors → err_cnt stays at 65535.
6. Assert rst_n=0 with 3 words in flight → outputs 0 immediately (async). Those words never produce mark_out. A new word after release appears at exactly latency 4.

Each reconstructed divident, fed through the mod-17 reducer, must return the original remainder (cross-check over 10^5 random legal (q,r) pairs).
